// File: rtl/seq_addsub_chunked.sv
// -----------------------------------------------------------------------------
// seq_addsub_chunked
//
// Multi-cycle adder/subtractor. One CHUNK-bit slice of the operands is added
// per clock. The carry between slices is kept in a register, so the critical
// path covers a CHUNK-bit add rather than a full WIDTH-bit ripple.
// An operation accepted in IDLE takes NCHUNK = WIDTH/CHUNK cycles in RUN.
// The result is then presented in DONE until the consumer takes it.
//
// Optional build macro:
//   ADDSUB_SAT_EN  - when defined, a signed overflow clamps z to the signed
//                    saturation value (0111..1 or 1000..0) on the final-slice
//                    edge; ovf still reads 1 and zero reflects the clamped z.
//                    When undefined, results wrap modulo 2^WIDTH.
//
// Parameters:
//   WIDTH     operand/result width; integer multiple of CHUNK
//   CHUNK     bits added per cycle (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands and mode valid
//   in_ready   block can accept an operation (IDLE and not in reset)
//   a, b       operands
//   sub        0: a+b, 1: a-b (two's complement)
//   out_valid  result and flags valid (state DONE)
//   out_ready  consumer accepts the result
//   z          sum / difference
//   cout       final carry-out (for subtract, 1 = no borrow)
//   ovf        signed overflow
//   zero       z == 0
// -----------------------------------------------------------------------------
module seq_addsub_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [CNT_W-1:0] LAST_K     = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef ADDSUB_SAT_EN
    // Signed saturation value for an overflowing result. The clamp direction
    // follows the sign of operand A: both operands share that sign whenever
    // overflow is possible.
    function automatic logic signed [WIDTH-1:0] sat_value(input logic neg);
        logic signed [WIDTH-1:0] v;
        if (neg) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // Control state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               carry_q, carry_d;

    // Latched operands; opb_q already holds ~b for subtract
    logic [WIDTH-1:0]   opa_q,   opa_d;
    logic [WIDTH-1:0]   opb_q,   opb_d;

    // Result registers
    logic [WIDTH-1:0]   z_q,     z_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;
    logic               zero_q,  zero_d;

    // Slice datapath
    int                 slice_lo;
    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK:0]     slice_sum;
    logic [WIDTH-1:0]   z_merged;
    logic               ovf_final;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign z         = z_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // ---- slice add: select slice k, add with the carry register, merge into z
    always_comb begin
        slice_lo  = int'(cnt_q) * CHUNK;
        a_slice   = CHUNK'(opa_q >> slice_lo);
        b_slice   = CHUNK'(opb_q >> slice_lo);
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + (CHUNK+1)'(carry_q);
        // Only slice k is replaced; the bits above it keep stale data until
        // their own slice cycle arrives.
        z_merged  = (z_q & ~(SLICE_MASK << slice_lo))
                  | (WIDTH'(slice_sum[CHUNK-1:0]) << slice_lo);
        // Evaluated on the merged word, so on the last slice it sees the
        // final MSB of the result.
        ovf_final = (opa_q[MSB] == opb_q[MSB]) && (z_merged[MSB] != opa_q[MSB]);
    end

    // ---- next-state and result update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Subtract as A + ~B + 1: the +1 enters as the
                    // initial carry into slice 0.
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                z_d     = z_merged;
                carry_d = slice_sum[CHUNK];
                if (cnt_q == LAST_K) begin
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = ovf_final;
`ifdef ADDSUB_SAT_EN
                    if (ovf_final) begin
                        z_d = sat_value(opa_q[MSB]);
                    end
`endif
                    zero_d  = (z_d == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // Results stay held; no new accept on the handshake edge.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- state / result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // ---- operand latches: written only on accept, no reset needed
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

endmodule

// File: tb/tb_seq_addsub_chunked.sv
module tb_seq_addsub_chunked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [2:0]       sub_v;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [2:0]       cout_v;
    logic [2:0]       ovf_v;
    logic [2:0]       zero_v;
    logic [2:0][31:0] a_v;
    logic [2:0][31:0] b_v;
    logic [2:0][31:0] z_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors: a, b, sub, z (wrap), z (saturate), cout, ovf
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] zw;
        logic [31:0] zs;
        logic        cout;
        logic        ovf;
    } vec_t;

    localparam int NV = 12;
    localparam vec_t VT [NV] = '{
        '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0},
        '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0},
        '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0},
        '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1},
        '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1},
        '{32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 32'h00000007, 1'b0, 1'b0},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 1'b1},
        '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 32'hACF13568, 1'b0, 1'b0},
        '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0},
        '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 32'h01000100, 1'b0, 1'b0},
        '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000001, 32'h80000000, 1'b1, 1'b1},
        '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1}
    };

    typedef struct {
        logic [31:0] z;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic void push_exp(input int g, input exp_t e);
        case (g)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int g);
        case (g)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h", nm, g, act, req);
        end
    endtask

    // DUT 0: CHUNK=8 (latency 4), DUT 1: CHUNK=32 (latency 1), DUT 2: CHUNK=1 (latency 32)
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int C   = (g == 0) ? 8 : (g == 1) ? 32 : 1;
        localparam int LAT = 32 / C;

        seq_addsub_chunked #(.WIDTH(32), .CHUNK(C)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .sub       (sub_v[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .z         (z_v[g]),
            .cout      (cout_v[g]),
            .ovf       (ovf_v[g]),
            .zero      (zero_v[g])
        );

        // Monitor: pops one expectation per result, checks hold and ready rules
        bit   seen    = 1'b0;
        bit   prev_ov = 1'b0;
        exp_t e;
        exp_t held;

        always @(negedge clk) begin
            if (reset) begin
                seen    = 1'b0;
                prev_ov = 1'b0;
            end else begin
                if (out_valid[g]) begin
                    chk("in_ready_in_done", g, in_ready[g], 1'b0);
                    if (!seen) begin
                        if (q_size(g) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output dut%0d actual=z:%h required=no_output", g, z_v[g]);
                        end else begin
                            e = pop_exp(g);
                            chk("z",       g, z_v[g],    e.z);
                            chk("cout",    g, cout_v[g], e.cout);
                            chk("ovf",     g, ovf_v[g],  e.ovf);
                            chk("zero",    g, zero_v[g], e.zero);
                            chk("latency", g, cyc - e.acc, LAT);
                        end
                        held.z    = z_v[g];
                        held.cout = cout_v[g];
                        held.ovf  = ovf_v[g];
                        held.zero = zero_v[g];
                        seen      = 1'b1;
                    end else begin
                        chk("z_hold",    g, z_v[g],    held.z);
                        chk("cout_hold", g, cout_v[g], held.cout);
                        chk("ovf_hold",  g, ovf_v[g],  held.ovf);
                        chk("zero_hold", g, zero_v[g], held.zero);
                    end
                end else begin
                    if (prev_ov) chk("in_ready_after_out", g, in_ready[g], 1'b1);
                    seen = 1'b0;
                end
                prev_ov = out_valid[g];
            end
        end
    end

    // Presents vector vi to DUT g from a negedge, waits for acceptance and
    // optionally queues the hand-computed expected result.
    task automatic drive(input int g, input int vi, input bit push);
        bit   ok = 1'b0;
        exp_t x;
        a_v[g]      = VT[vi].a;
        b_v[g]      = VT[vi].b;
        sub_v[g]    = VT[vi].sub;
        in_valid[g] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (in_ready[g]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d actual=in_ready_low required=accept", g);
            in_valid[g] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[g] = 1'b0;
        // Scramble the inputs: the DUT must not sample them after accept.
        a_v[g]      = 32'hDEADBEEF;
        b_v[g]      = 32'h5A5A5A5A;
        sub_v[g]    = ~VT[vi].sub;
        if (push) begin
`ifdef ADDSUB_SAT_EN
            x.z = VT[vi].zs;
`else
            x.z = VT[vi].zw;
`endif
            x.cout = VT[vi].cout;
            x.ovf  = VT[vi].ovf;
            x.zero = (x.z == 32'h0);
            x.acc  = cyc;
            push_exp(g, x);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && out_valid == 3'b000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=pending:%0d/%0d/%0d required=0", q0.size(), q1.size(), q2.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        sub_v     = '0;
        a_v       = '0;
        b_v       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_in_ready",  g, in_ready[g],  1'b0);
            chk("rst_out_valid", g, out_valid[g], 1'b0);
            chk("rst_z",         g, z_v[g],       32'h0);
            chk("rst_flags",     g, {cout_v[g], ovf_v[g], zero_v[g]}, 3'b000);
        end
        reset = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) chk("in_ready_post_rst", g, in_ready[g], 1'b1);
        @(negedge clk);

        // All vectors through all three chunk sizes
        fork
            begin
                for (int i = 0; i < NV; i++) drive(0, i, 1'b1);
            end
            begin
                for (int j = 0; j < NV; j++) drive(1, j, 1'b1);
            end
            begin
                for (int k = 0; k < NV; k++) drive(2, k, 1'b1);
            end
        join
        wait_idle();

        // Backpressure: result held 3 extra cycles, pending in_valid ignored
        out_ready[0] = 1'b0;
        drive(0, 3, 1'b1);
        for (int t = 0; t < 50; t++) begin
            if (out_valid[0]) break;
            @(negedge clk);
        end
        chk("bp_out_valid", 0, out_valid[0], 1'b1);
        fork
            drive(0, 9, 1'b1);
            begin
                repeat (3) @(negedge clk);
                out_ready[0] = 1'b1;
            end
        join
        wait_idle();

        // Reset two cycles after accept: operation abandoned
        drive(0, 7, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 0, out_valid[0], 1'b0);
        chk("midrst_z",         0, z_v[0],       32'h0);
        chk("midrst_flags",     0, {cout_v[0], ovf_v[0], zero_v[0]}, 3'b000);
        chk("midrst_in_ready",  0, in_ready[0],  1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", 0, in_ready[0], 1'b1);
        drive(0, 5, 1'b1);
        repeat (10) @(negedge clk);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_addsub_chunked.md
Name: seq_addsub_chunked

Overview:
Multi-cycle, parametrised adder/subtractor. It is the sequential successor of the flat 32-bit ripple adder used in the single-cycle datapath. Each cycle it adds one CHUNK-bit slice of the operands, propagating the carry between slices in a register. This trades latency for a short critical path. It is intended for the multi-cycle/pipelined datapath and returns carry-out, signed overflow and zero flags. It uses valid/ready handshakes on both input and output.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK
CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH
NCHUNK (localparam), WIDTH/CHUNK, number of slice cycles per operation

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode are valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B (two's complement)
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer accepts the result
z  output  WIDTH  sum/difference
cout  output  1  final carry-out; for sub, 1 = no borrow
ovf  output  1  signed overflow
zero  output  1  z == 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE. A synchronous reset forces IDLE from any state.
- Reset values:
  - state = IDLE, slice counter = 0, carry = 0.
  - z = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready = 0 while reset is high.
- in_ready = (state == IDLE) && !reset. It is combinational from state and is never asserted in RUN or DONE.
- out_valid = (state == DONE), registered.
- IDLE:
  - Accept when in_valid && in_ready.
  - On accept, latch opA = a, opB = b XOR {WIDTH{sub}}, carry = sub, counter = 0, then go to RUN.
  - Operands are not sampled at any other time.
- RUN, each cycle:
  - {c, s} = opA[k*CHUNK +: CHUNK] + opB[k*CHUNK +: CHUNK] + carry, where k = counter and the add is CHUNK+1 bits wide.
  - Write s into z[k*CHUNK +: CHUNK]; carry <= c; counter++.
  - When k == NCHUNK-1: cout <= c, compute the flags, and go to DONE.
- Flags:
  - ovf = (opA[MSB] == opB[MSB]) && (z[MSB] != opA[MSB]), using the inverted opB for subtract.
  - zero = (final z == 0).
  - Both are registered on the same edge as the final slice.
- Latency: the accept edge is cycle 0; out_valid rises after exactly NCHUNK further rising edges.
  - CHUNK = WIDTH gives 1-cycle latency.
  - CHUNK = 1 gives a WIDTH-cycle latency.
- DONE:
  - z, cout, ovf and zero are held stable while out_valid = 1.
  - On out_valid && out_ready, go to IDLE on that edge; outputs keep their values, but out_valid = 0.
  - There is no accept in the same cycle as the output handshake; the next accept is possible one cycle later. Maximum throughput is 1 op per NCHUNK+2 cycles.
- Partial z: bits of z above slice k hold stale data during RUN. Consumers must use z only when out_valid = 1.
- Reset mid-operation (RUN or DONE): the operation is abandoned and no out_valid is produced. in_ready returns 1 on the first cycle after reset deasserts.
- in_valid during RUN/DONE is ignored; the upstream must hold it until in_ready.
- Arithmetic wraps modulo 2^WIDTH. Carries out of slices never leak beyond the final cout.

Optional Feature:
ADDSUB_SAT_EN
- Defined: on signed overflow, z is replaced in DONE by the signed saturation value.
  - 0 + 0111…1 when opA[MSB] = 0.
  - 1000…0 when opA[MSB] = 1.
  - ovf is still reported as 1.
  - zero is computed on the saturated z.
  - Latency is unchanged; the clamp is applied on the final-slice edge.
- Undefined: the result wraps modulo 2^WIDTH, and no clamp logic is present.

Test Plan:
1. WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, sub=0 -> out_valid 4 cycles after accept; z=0x00000000, cout=1, ovf=0, zero=1.
2. Subtract: a=5, b=7, sub=1 -> z=0xFFFFFFFE, cout=0, ovf=0, zero=0. Also a=7, b=7, sub=1 -> z=0, cout=1, zero=1.
3. Overflow: a=0x7FFFFFFF, b=1, sub=0 -> z=0x80000000, ovf=1. With ADDSUB_SAT_EN -> z=0x7FFFFFFF, ovf=1. Also a=0x80000000, b=1, sub=1 -> sat z=0x80000000 / wrap z=0x7FFFFFFF, ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid -> z and flags constant, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 on the following cycle, and the next op is accepted.
5. Reset mid-RUN: assert reset 2 cycles after accept for 1 cycle -> out_valid never asserts, outputs are 0, in_ready=1 the cycle after reset drops. A following op of 3+4 gives z=7.
6. Parameter sweep: CHUNK=32 (latency 1) and CHUNK=1 (latency 32) -> random a/b/sub vectors match a reference a±b, carry and overflow model exactly.
